// File: rtl/alu_pkg.sv
// Shared encodings for the execute unit: RV32I opcodes, funct fields and FSM states.
package alu_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } instruction_type;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M datapath: shift-add multiply and restoring divide on operand
// magnitudes, one step per cycle for XLEN cycles, signs restored on the result.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W  = $clog2(XLEN);
    localparam int unsigned PROD_W = 2 * XLEN;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic              running;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q;
    logic              neg_r;
    logic              div0;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   dvsr;

    logic              a_neg_c;
    logic              b_neg_c;
    logic [XLEN-1:0]   a_mag_c;
    logic [XLEN-1:0]   b_mag_c;
    logic [XLEN:0]     rem_sh_c;
    logic [XLEN:0]     diff_c;
    logic              ge_c;

    // Operand signedness and magnitudes at start
    always_comb begin
        a_neg_c = a[XLEN-1] && (op == F3_MULH || op == F3_MULHSU || op == F3_DIV || op == F3_REM);
        b_neg_c = b[XLEN-1] && (op == F3_MULH || op == F3_DIV || op == F3_REM);
        a_mag_c = a_neg_c ? -a : a;
        b_mag_c = b_neg_c ? -b : b;
    end

    // One restoring-division step: shift in next dividend bit, subtract if it fits
    always_comb begin
        rem_sh_c = {rem, quo[XLEN-1]};
        diff_c   = rem_sh_c - {1'b0, dvsr};
        ge_c     = rem_sh_c >= {1'b0, dvsr};
    end

    assign done = running && (cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= 3'd0;
            a_q     <= '0;
            running <= 1'b0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
        end else if (start) begin
            op_q    <= op;
            a_q     <= a;
            running <= 1'b1;
            cnt     <= '0;
            neg_q   <= a_neg_c ^ b_neg_c;
            neg_r   <= a_neg_c;
            div0    <= op[2] && (b == '0);
            prod    <= '0;
            mcand   <= {{XLEN{1'b0}}, a_mag_c};
            mplier  <= b_mag_c;
            quo     <= a_mag_c;
            rem     <= '0;
            dvsr    <= b_mag_c;
        end else if (running) begin
            cnt <= cnt + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
            end
            if (op_q[2]) begin
                rem <= ge_c ? diff_c[XLEN-1:0] : rem_sh_c[XLEN-1:0];
                quo <= {quo[XLEN-2:0], ge_c};
            end else begin
                if (mplier[0]) begin
                    prod <= prod + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    logic [PROD_W-1:0] prod_s_c;
    logic [XLEN-1:0]   quo_s_c;
    logic [XLEN-1:0]   rem_s_c;

    // Sign fix-up and divide-by-zero override
    always_comb begin
        prod_s_c = neg_q ? -prod : prod;
        quo_s_c  = neg_q ? -quo : quo;
        rem_s_c  = neg_r ? -rem : rem;
        case (op_q)
            F3_MUL:                        result = prod_s_c[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  result = prod_s_c[PROD_W-1:XLEN];
            F3_DIV, F3_DIVU:               result = div0 ? '1 : quo_s_c;
            F3_REM, F3_REMU:               result = div0 ? a_q : rem_s_c;
            default:                       result = '0;
        endcase
    end

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked execute unit: registered RV32I ALU/branch/address ops in one cycle,
// RV32M ops through the iterative muldiv_iter datapath.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHAMT_W    = $clog2(XLEN),
    parameter bit          EARLY_DIV0 = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      op_code,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] input1_value,
    input  logic [XLEN-1:0] input2_value,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_output_value,
    output logic            busy
);

    state_t          state;
    state_t          state_nx;
    logic            ready_q;
    logic            is_m_c;
    logic            div_zero_c;
    logic            accept_m;
    logic            accept_base;
    logic            load_md;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic [XLEN-1:0] alu_c;

    assign is_m_c     = (op_code == OP_REG) && (funct7 == F7_MULDIV);
    assign div_zero_c = funct3[2] && (input2_value == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept_m) state_nx = (EARLY_DIV0 && div_zero_c) ? DONE : ITER;
            ITER: if (md_done) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ready_q keeps in_ready low for the first cycle out of reset
    always_comb begin
        in_ready    = ready_q && (state == IDLE) && (!out_valid || out_ready);
        busy        = (state != IDLE);
        accept_m    = in_valid && in_ready && is_m_c;
        accept_base = in_valid && in_ready && !is_m_c;
        load_md     = (state == DONE);
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept_m),
        .op     (funct3),
        .a      (input1_value),
        .b      (input2_value),
        .done   (md_done),
        .result (md_result)
    );

    logic [XLEN-1:0]    sum_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic               alt_c;
    logic               taken_c;

    // Base RV32I operations; unknown opcodes or funct3 yield zero
    always_comb begin
        sum_c   = input1_value + input2_value;
        shamt_c = input2_value[SHAMT_W-1:0];
        alt_c   = (funct7 == F7_ALT);
        taken_c = 1'b0;
        alu_c   = '0;
        case (op_code)
            OP_REG, OP_IMM: begin
                case (funct3)
                    F3_ADD:  alu_c = (op_code == OP_REG && alt_c) ? input1_value - input2_value : sum_c;
                    F3_SLL:  alu_c = input1_value << shamt_c;
                    F3_SLT:  alu_c = {{(XLEN-1){1'b0}}, $signed(input1_value) < $signed(input2_value)};
                    F3_SLTU: alu_c = {{(XLEN-1){1'b0}}, input1_value < input2_value};
                    F3_XOR:  alu_c = input1_value ^ input2_value;
                    F3_SR:   alu_c = alt_c ? XLEN'($signed(input1_value) >>> shamt_c) : input1_value >> shamt_c;
                    F3_OR:   alu_c = input1_value | input2_value;
                    F3_AND:  alu_c = input1_value & input2_value;
                    default: alu_c = '0;
                endcase
            end
            OP_LOAD, OP_STORE, OP_AUIPC, OP_JAL: alu_c = sum_c;
            OP_JALR: alu_c = {sum_c[XLEN-1:1], 1'b0};
            OP_LUI:  alu_c = input2_value;
            OP_BRANCH: begin
                case (funct3)
                    F3_BEQ:  taken_c = input1_value == input2_value;
                    F3_BNE:  taken_c = input1_value != input2_value;
                    F3_BLT:  taken_c = $signed(input1_value) < $signed(input2_value);
                    F3_BGE:  taken_c = $signed(input1_value) >= $signed(input2_value);
                    F3_BLTU: taken_c = input1_value < input2_value;
                    F3_BGEU: taken_c = input1_value >= input2_value;
                    default: taken_c = 1'b0;
                endcase
                alu_c = {XLEN{taken_c}};
            end
            default: alu_c = '0;
        endcase
    end

    // Result register: held until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q          <= 1'b0;
            out_valid        <= 1'b0;
            alu_output_value <= '0;
        end else begin
            ready_q <= 1'b1;
            if (accept_base) begin
                out_valid        <= 1'b1;
                alu_output_value <= alu_c;
            end else if (load_md) begin
                out_valid        <= 1'b1;
                alu_output_value <= md_result;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed scenarios plus randomized ops
// against a plain-arithmetic reference model.
module tb_alu_muldiv;

    localparam int unsigned XLEN  = 32;
    localparam int          LAT_M = XLEN + 2;

    localparam logic [6:0] O_R = 7'h33, O_I = 7'h13, O_LD = 7'h03, O_ST = 7'h23, O_B = 7'h63;
    localparam logic [6:0] O_JAL = 7'h6F, O_JALR = 7'h67, O_LUI = 7'h37, O_AUIPC = 7'h17;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  op_code;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] input1_value;
    logic [31:0] input2_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_output_value;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(XLEN), .EARLY_DIV0(1'b1)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .op_code          (op_code),
        .funct3           (funct3),
        .funct7           (funct7),
        .input1_value     (input1_value),
        .input2_value     (input2_value),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .alu_output_value (alu_output_value),
        .busy             (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour from the instruction semantics
    function automatic logic [31:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [4:0]  sh;
        logic        ovf;
        sh  = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        model = 32'h0;
        if (op == O_R && f7 == 7'h01) begin
            case (f3)
                3'd0: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); model = p[31:0]; end
                3'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); model = p[63:32]; end
                3'd2: begin p = 64'(longint'($signed(a)) * longint'({32'h0, b})); model = p[63:32]; end
                3'd3: begin p = {32'h0, a} * {32'h0, b}; model = p[63:32]; end
                3'd4: model = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
                3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: model = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
                default: model = (b == 0) ? a : a % b;
            endcase
        end else if (op == O_R || op == O_I) begin
            case (f3)
                3'd0: model = (op == O_R && f7 == 7'h20) ? a - b : a + b;
                3'd1: model = a << sh;
                3'd2: model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: model = (a < b) ? 32'd1 : 32'd0;
                3'd4: model = a ^ b;
                3'd5: model = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
                3'd6: model = a | b;
                default: model = a & b;
            endcase
        end else if (op == O_LD || op == O_ST || op == O_AUIPC || op == O_JAL) begin
            model = a + b;
        end else if (op == O_JALR) begin
            model = (a + b) & 32'hFFFF_FFFE;
        end else if (op == O_LUI) begin
            model = b;
        end else if (op == O_B) begin
            case (f3)
                3'd0: model = (a == b) ? '1 : '0;
                3'd1: model = (a != b) ? '1 : '0;
                3'd4: model = ($signed(a) < $signed(b)) ? '1 : '0;
                3'd5: model = ($signed(a) >= $signed(b)) ? '1 : '0;
                3'd6: model = (a < b) ? '1 : '0;
                3'd7: model = (a >= b) ? '1 : '0;
                default: model = 32'h0;
            endcase
        end
    endfunction

    // Present one op, wait for accept, scramble operands, then wait for the result.
    // lat counts cycles with the cycle right after the accept edge as 1.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit ok);
        int w;
        op_code = op; funct3 = f3; funct7 = f7; input1_value = a; input2_value = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin tick(); w++; end
        ok = 1'b0; lat = 0; res = 32'h0;
        if (!in_ready) begin in_valid = 1'b0; return; end
        tick();
        in_valid = 1'b0;
        input1_value = $urandom; input2_value = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin tick(); lat++; end
        ok  = out_valid;
        res = alu_output_value;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_code = 7'h0; funct3 = 3'h0; funct7 = 7'h0; input1_value = 32'h0; input2_value = 32'h0;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (alu_output_value !== 32'h0) begin errors++; $display("FAIL reset_value: got %h expected 0", alu_output_value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b0; tick();
        op_code = O_R; funct3 = 3'd0; funct7 = 7'h00; input1_value = 32'd5; input2_value = 32'd7; in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || alu_output_value !== 32'd12)
            begin errors++; $display("FAIL b2b_add: got v=%b %h expected v=1 0000000c", out_valid, alu_output_value); end
        funct7 = 7'h20;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || alu_output_value !== 32'hFFFF_FFFE)
            begin errors++; $display("FAIL b2b_sub: got v=%b %h expected v=1 fffffffe", out_valid, alu_output_value); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_shifts();
        logic [31:0] r; int lat; bit ok;
        out_ready = 1'b1;
        run_op(O_R, 3'd5, 7'h20, 32'h8000_0000, 32'd4, r, lat, ok);
        checks++; if (!ok || r !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h ok=%b expected f8000000", r, ok); end
        run_op(O_R, 3'd5, 7'h00, 32'h8000_0000, 32'h24, r, lat, ok);
        checks++; if (!ok || r !== 32'h0800_0000) begin errors++; $display("FAIL srl_shamt: got %h ok=%b expected 08000000", r, ok); end
    endtask

    task automatic test_mul();
        logic [2:0]  f3s [3] = '{3'd1, 3'd3, 3'd0};
        logic [31:0] as  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] bs  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        logic [31:0] exp [3] = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFEB};
        logic [31:0] r; int lat; bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(O_R, f3s[i], 7'h01, as[i], bs[i], r, lat, ok);
            checks++; if (!ok || r !== exp[i]) begin errors++; $display("FAIL mul%0d: got %h ok=%b expected %h", i, r, ok, exp[i]); end
            checks++; if (lat != LAT_M) begin errors++; $display("FAIL mul%0d_latency: got %0d expected %0d", i, lat, LAT_M); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3s [6] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd9};
        int          lats[6] = '{LAT_M, LAT_M, LAT_M, LAT_M, 2, 2};
        logic [31:0] r; int lat; bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(O_R, f3s[i], 7'h01, as[i], bs[i], r, lat, ok);
            checks++; if (!ok || r !== exp[i]) begin errors++; $display("FAIL div%0d: got %h ok=%b expected %h", i, r, ok, exp[i]); end
            checks++; if (lat != lats[i]) begin errors++; $display("FAIL div%0d_latency: got %0d expected %0d", i, lat, lats[i]); end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b1; in_valid = 1'b0; tick();
        out_ready = 1'b0;
        op_code = O_R; funct3 = 3'd0; funct7 = 7'h00; input1_value = 32'h1234; input2_value = 32'h1111; in_valid = 1'b1;
        tick();
        funct3 = 3'd4; input1_value = 32'hF0F0_0000; input2_value = 32'h0F0F_0000;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || alu_output_value !== 32'h2345 || in_ready !== 1'b0)
                begin errors++; $display("FAIL stall%0d: got v=%b %h rdy=%b expected v=1 00002345 rdy=0", i, out_valid, alu_output_value, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || alu_output_value !== 32'hFFFF_0000)
            begin errors++; $display("FAIL stall_release: got v=%b %h expected v=1 ffff0000", out_valid, alu_output_value); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int lat; bit ok; bit seen;
        out_ready = 1'b1; in_valid = 1'b0; tick();
        op_code = O_R; funct3 = 3'd5; funct7 = 7'h01; input1_value = $urandom; input2_value = 32'd3; in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b expected 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL rmid_reset: got rdy=%b busy=%b v=%b expected 0 0 0", in_ready, busy, out_valid); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_back: got %b expected 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < XLEN + 4; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_result: got out_valid=1 expected none"); end
        run_op(O_R, 3'd0, 7'h00, 32'd100, 32'd23, r, lat, ok);
        checks++; if (!ok || r !== 32'd123 || lat != 1) begin errors++; $display("FAIL rmid_add: got %h lat=%0d expected 0000007b lat=1", r, lat); end
    endtask

    task automatic test_random();
        logic [6:0]  ops [10] = '{O_R, O_I, O_LD, O_ST, O_B, O_JAL, O_JALR, O_LUI, O_AUIPC, 7'h7F};
        logic [31:0] sp  [5]  = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7};
        logic [6:0]  op, f7; logic [2:0] f3; logic [31:0] a, b, exp, r;
        int lat, exp_lat; bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(0, 9)];
            f3 = 3'($urandom);
            f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            if (op == O_R && $urandom_range(0, 2) == 0) f7 = 7'h01;
            a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
            exp = model(op, f3, f7, a, b);
            exp_lat = (op == O_R && f7 == 7'h01) ? ((f3[2] && b == 0) ? 2 : LAT_M) : 1;
            run_op(op, f3, f7, a, b, r, lat, ok);
            checks++; if (!ok || r !== exp)
                begin errors++; $display("FAIL rand%0d op=%h f3=%0d f7=%h a=%h b=%h: got %h ok=%b expected %h", i, op, f3, f7, a, b, r, ok, exp); end
            checks++; if (lat != exp_lat)
                begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shifts();
        test_mul();
        test_div();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
